ads_eeg_frame_reader: RTL and testbench
=======================================

Name: ads_eeg_frame_reader

Overview:
SPI master for an 8-channel 24-bit EEG ADC running in read-data-continuous mode. On each DRDY falling edge it reads one frame: a 24-bit status word followed by eight 24-bit channel words. It validates the status header and streams the channel words out as raw_adc_out / adc_channel_sel / adc_data_ready pulses. It sits directly upstream of the cursor top-level ADC input (raw_adc_in, adc_channel_sel, adc_data_ready).

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period (>=2)
NUM_CH, 8, channel words per frame
WORD_BITS, 24, bits per status/channel word
STATUS_HDR, 4'hC, required value of status word bits [23:20]

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  allow new frames to start
drdy_n  in  1  ADC data-ready, async, active-low
spi_miso  in  1  ADC serial data out
spi_sclk  out  1  SPI clock, CPOL=0
spi_cs_n  out  1  chip select, active-low
raw_adc_out  out  24  last emitted channel sample (two's complement)
adc_channel_sel  out  3  channel index of raw_adc_out
adc_data_ready  out  1  one-cycle strobe: raw_adc_out/adc_channel_sel valid
status_word  out  24  last received status word
frame_err  out  1  sticky-per-frame: last frame header mismatch
overrun_cnt  out  8  saturating count of DRDY edges missed while busy
busy  out  1  high when not IDLE

Behaviour:
- Reset values: spi_sclk=0, spi_cs_n=1, raw_adc_out=0, adc_channel_sel=0, adc_data_ready=0, status_word=0, frame_err=0, overrun_cnt=0, busy=0, state=IDLE.
- drdy_n passes a 2-flop synchronizer, then a falling-edge detect register (fall = prev 1, now 0).
- States: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> IDLE.
- IDLE: on fall && enable, go to CS_SETUP next cycle. spi_cs_n=0 and busy=1 from that cycle. fall with enable=0 is ignored and not counted.
- CS_SETUP: hold CLK_DIV cycles with sclk=0, then enter SHIFT.
- SHIFT, SPI mode 1:
  - div counter 0..CLK_DIV-1; at terminal count spi_sclk toggles.
  - On each 1->0 toggle, sample spi_miso MSB-first into the shift register and increment bit_cnt.
  - Total (NUM_CH+1)*WORD_BITS = 216 falling edges; one bit = 2*CLK_DIV clk.
- Word completion is the cycle after the 24th sample of a word.
  - Word 0 (status): status_word loads. frame_err = (bits[23:20] != STATUS_HDR).
  - Words 1..8: if frame_err=0, raw_adc_out = word, adc_channel_sel = index-1, adc_data_ready pulses for 1 cycle. If frame_err=1, no pulse and raw_adc_out holds.
- After the 216th falling edge: CS_HOLD for CLK_DIV cycles, sclk=0; then spi_cs_n=1, busy=0, IDLE.
- Frame length from cs_n low to cs_n high: CLK_DIV*(2*216+2) clk (1736 at CLK_DIV=4).
- fall while state != IDLE: the frame is not restarted; overrun_cnt increments, saturating at 255.
- enable deasserted mid-frame: the current frame completes normally.
- rst mid-frame: next cycle spi_cs_n=1, spi_sclk=0, all outputs at reset values. No partial-word strobe.
- Strobes are always separated by >= 2*CLK_DIV*WORD_BITS clk. adc_channel_sel is strictly 0..7 in order within a frame.

Decomposition:
- Shared package eeg_adc_pkg: state enum (IDLE, CS_SETUP, SHIFT, CS_HOLD), FRAME_WORDS=9, FRAME_BITS=216, STATUS_HDR default.
- Sub-module drdy_sync_edge: 2-flop synchronizer plus falling-edge pulse; reusable for other async strobes.
- SCLK divider and shift logic stay inline.

Test Plan:
- Frame with status 0xC00000 and channel words 0x000001, 0x7FFFFF, 0x800000, 0x123456, 0xABCDEF, 0, 0xFFFFFF, 0x55AA55 -> eight strobes with channel_sel 0..7 and exactly these values; status_word=0xC00000; frame_err=0; cs_n low for exactly 1736 clk.
- Status 0x400000 -> frame_err=1, zero strobes, raw_adc_out keeps its previous value; next good frame clears frame_err and emits 8 strobes.
- Second drdy_n falling edge 500 clk into a frame -> overrun_cnt=1, frame completes with 8 strobes. 300 such events -> overrun_cnt=255.
- enable=0 at DRDY edge -> cs_n stays 1, no strobes, overrun_cnt unchanged. enable dropped mid-frame -> frame completes.
- rst asserted at bit 100 -> next cycle cs_n=1, sclk=0, busy=0, outputs zero. The following DRDY edge yields a clean full frame.
- SCLK check at CLK_DIV=2 and CLK_DIV=4: high/low widths exactly CLK_DIV clk, 216 rising edges, miso sampled only on falling edges (bench toggles miso on rising edges).

Source files
------------

// File: rtl/eeg_adc_pkg.sv
// Shared types and frame geometry for the EEG ADC frame reader.
package eeg_adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD
  } state_t;

  localparam int          NUM_CH_DEFAULT    = 8;
  localparam int          WORD_BITS_DEFAULT = 24;
  localparam int          FRAME_WORDS       = NUM_CH_DEFAULT + 1;
  localparam int          FRAME_BITS        = FRAME_WORDS * WORD_BITS_DEFAULT;
  localparam logic [3:0]  STATUS_HDR_DEFAULT = 4'hC;

endpackage

// File: rtl/ads_eeg_frame_reader_if.sv
// ADC-side pins plus the sample stream towards the ADC input of the cursor top level.
interface ads_eeg_frame_reader_if
  import eeg_adc_pkg::*;
#(
  parameter int WORD_BITS = WORD_BITS_DEFAULT,
  parameter int CH_W      = $clog2(NUM_CH_DEFAULT)
);
  logic                 enable;
  logic                 drdy_n;
  logic                 spi_miso;
  logic                 spi_sclk;
  logic                 spi_cs_n;
  logic [WORD_BITS-1:0] raw_adc_out;
  logic [CH_W-1:0]      adc_channel_sel;
  logic                 adc_data_ready;
  logic [WORD_BITS-1:0] status_word;
  logic                 frame_err;
  logic [7:0]           overrun_cnt;
  logic                 busy;

  modport master (
    input  enable, drdy_n, spi_miso,
    output spi_sclk, spi_cs_n, raw_adc_out, adc_channel_sel, adc_data_ready,
           status_word, frame_err, overrun_cnt, busy
  );

  modport slave (
    output enable, drdy_n, spi_miso,
    input  spi_sclk, spi_cs_n, raw_adc_out, adc_channel_sel, adc_data_ready,
           status_word, frame_err, overrun_cnt, busy
  );
endinterface

// File: rtl/drdy_sync_edge.sv
// Two-flop synchronizer for an asynchronous active-low strobe, plus a falling-edge pulse.
module drdy_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async_n,
  output logic o_fall
);
  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Reset to the inactive (high) level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_async_n;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_fall = r_prev & ~r_sync;
endmodule

// File: rtl/ads_eeg_frame_reader.sv
// SPI mode-1 master reading one status word plus NUM_CH channel words per DRDY edge,
// streaming the channel words out as one-cycle strobes when the status header is valid.
module ads_eeg_frame_reader
  import eeg_adc_pkg::*;
#(
  parameter int         CLK_DIV    = 4,
  parameter int         NUM_CH     = NUM_CH_DEFAULT,
  parameter int         WORD_BITS  = WORD_BITS_DEFAULT,
  parameter logic [3:0] STATUS_HDR = STATUS_HDR_DEFAULT
) (
  input logic                   clk,
  input logic                   rst,
  ads_eeg_frame_reader_if.master bus
);
  localparam int TOTAL_BITS = (NUM_CH + 1) * WORD_BITS;
  localparam int DIV_W      = $clog2(CLK_DIV);
  localparam int BIT_W      = $clog2(TOTAL_BITS);
  localparam int BW_W       = $clog2(WORD_BITS);
  localparam int WI_W       = $clog2(NUM_CH + 1);
  localparam int CH_W       = $clog2(NUM_CH);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TOTAL_BITS - 1);
  localparam logic [BW_W-1:0]  BW_LAST  = BW_W'(WORD_BITS - 1);

  logic                 w_fall;
  state_t               r_state;
  logic [DIV_W-1:0]     r_div;
  logic                 r_sclk;
  logic                 r_cs_n;
  logic                 r_busy;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [BW_W-1:0]      r_bit_in_word;
  logic [WI_W-1:0]      r_word_idx;
  logic [WI_W-1:0]      r_done_idx;
  logic                 r_word_done;
  logic [WORD_BITS-1:0] r_shift;
  logic [WORD_BITS-1:0] r_raw;
  logic [CH_W-1:0]      r_sel;
  logic                 r_ready;
  logic [WORD_BITS-1:0] r_status;
  logic                 r_frame_err;
  logic [7:0]           r_overrun;

  drdy_sync_edge u_drdy (
    .clk       (clk),
    .rst       (rst),
    .i_async_n (bus.drdy_n),
    .o_fall    (w_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_div         <= '0;
      r_sclk        <= 1'b0;
      r_cs_n        <= 1'b1;
      r_busy        <= 1'b0;
      r_bit_cnt     <= '0;
      r_bit_in_word <= '0;
      r_word_idx    <= '0;
      r_done_idx    <= '0;
      r_word_done   <= 1'b0;
      r_shift       <= '0;
      r_raw         <= '0;
      r_sel         <= '0;
      r_ready       <= 1'b0;
      r_status      <= '0;
      r_frame_err   <= 1'b0;
      r_overrun     <= '0;
    end else begin
      // NOTE: strobes default low here; a later non-blocking assignment in this block wins.
      r_ready     <= 1'b0;
      r_word_done <= 1'b0;

      if (w_fall && (r_state != IDLE) && (r_overrun != 8'hFF))
        r_overrun <= r_overrun + 8'd1;

      // A completed word is consumed one cycle after its last sample, also in CS_HOLD.
      if (r_word_done) begin
        if (r_done_idx == '0) begin
          r_status    <= r_shift;
          r_frame_err <= (r_shift[WORD_BITS-1 -: 4] != STATUS_HDR);
        end else if (!r_frame_err) begin
          r_raw   <= r_shift;
          r_sel   <= CH_W'(r_done_idx - WI_W'(1));
          r_ready <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (w_fall && bus.enable) begin
            r_state       <= CS_SETUP;
            r_cs_n        <= 1'b0;
            r_busy        <= 1'b1;
            r_div         <= '0;
            r_bit_cnt     <= '0;
            r_bit_in_word <= '0;
            r_word_idx    <= '0;
          end
        end
        CS_SETUP: begin
          if (r_div == DIV_LAST) begin
            r_div   <= '0;
            r_state <= SHIFT;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        SHIFT: begin
          if (r_div == DIV_LAST) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
              r_shift   <= {r_shift[WORD_BITS-2:0], bus.spi_miso};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_in_word == BW_LAST) begin
                r_bit_in_word <= '0;
                r_word_done   <= 1'b1;
                r_done_idx    <= r_word_idx;
                r_word_idx    <= r_word_idx + 1'b1;
              end else begin
                r_bit_in_word <= r_bit_in_word + 1'b1;
              end
              if (r_bit_cnt == BIT_LAST)
                r_state <= CS_HOLD;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        CS_HOLD: begin
          if (r_div == DIV_LAST) begin
            r_div   <= '0;
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.spi_sclk        = r_sclk;
  assign bus.spi_cs_n        = r_cs_n;
  assign bus.raw_adc_out     = r_raw;
  assign bus.adc_channel_sel = r_sel;
  assign bus.adc_data_ready  = r_ready;
  assign bus.status_word     = r_status;
  assign bus.frame_err       = r_frame_err;
  assign bus.overrun_cnt     = r_overrun;
  assign bus.busy            = r_busy;
endmodule

// File: tb/tb_ads_eeg_frame_reader.sv
// Bench for ads_eeg_frame_reader: an ADC model serves random frames, a frame-level model predicts the outputs.
module tb_ads_eeg_frame_reader;
  import eeg_adc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ads_eeg_frame_reader_if bus4 ();
  ads_eeg_frame_reader_if bus2 ();

  ads_eeg_frame_reader #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.master));
  ads_eeg_frame_reader #(.CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level expectations
  logic [23:0] fw4 [FRAME_WORDS];
  logic [23:0] fw2 [FRAME_WORDS];
  logic [23:0] exp_raw, exp_status;
  logic [2:0]  exp_sel;
  logic        exp_err;
  int          exp_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ADC models: data changes on SCLK rising edges, MSB first; wrong bit parked before the first edge.
  int k4 = 0;
  int k2 = 0;
  always @(negedge bus4.spi_cs_n) begin k4 = 0; bus4.spi_miso = ~fw4[0][23]; end
  always @(posedge bus4.spi_sclk)
    if (!bus4.spi_cs_n && k4 < FRAME_BITS) begin
      bus4.spi_miso = fw4[k4 / 24][23 - (k4 % 24)];
      k4++;
    end
  always @(negedge bus2.spi_cs_n) begin k2 = 0; bus2.spi_miso = ~fw2[0][23]; end
  always @(posedge bus2.spi_sclk)
    if (!bus2.spi_cs_n && k2 < FRAME_BITS) begin
      bus2.spi_miso = fw2[k2 / 24][23 - (k2 % 24)];
      k2++;
    end

  // Pin monitor, index 0 = CLK_DIV 4 instance, index 1 = CLK_DIV 2 instance
  logic [1:0] m_cs, m_sclk, m_rdy;
  assign m_cs   = {bus2.spi_cs_n, bus4.spi_cs_n};
  assign m_sclk = {bus2.spi_sclk, bus4.spi_sclk};
  assign m_rdy  = {bus2.adc_data_ready, bus4.adc_data_ready};

  logic [26:0] q4 [$];
  logic [26:0] q2 [$];
  int  cs_len [2], len_last [2], rises [2], falls [2], run_len [2];
  int  hi_min [2], hi_max [2], lo_min [2], lo_max [2], gap_min [2], last_t [2];
  bit  seen_hi [2], have_strobe [2];
  logic prev_cs [2] = '{1'b1, 1'b1};
  logic prev_sclk [2] = '{1'b0, 1'b0};
  int  cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus4.adc_data_ready) q4.push_back({bus4.adc_channel_sel, bus4.raw_adc_out});
    if (bus2.adc_data_ready) q2.push_back({bus2.adc_channel_sel, bus2.raw_adc_out});
    for (int d = 0; d < 2; d++) begin
      if (!m_cs[d]) begin
        if (prev_cs[d]) begin
          cs_len[d] = 0; rises[d] = 0; falls[d] = 0; run_len[d] = 0;
          hi_min[d] = 1 << 30; hi_max[d] = 0; lo_min[d] = 1 << 30; lo_max[d] = 0;
          gap_min[d] = 1 << 30; seen_hi[d] = 0; have_strobe[d] = 0;
        end
        cs_len[d]++;
        if (m_sclk[d] != prev_sclk[d]) begin
          if (prev_sclk[d]) begin
            falls[d]++;
            hi_min[d] = (run_len[d] < hi_min[d]) ? run_len[d] : hi_min[d];
            hi_max[d] = (run_len[d] > hi_max[d]) ? run_len[d] : hi_max[d];
            seen_hi[d] = 1;
          end else begin
            rises[d]++;
            if (seen_hi[d]) begin
              lo_min[d] = (run_len[d] < lo_min[d]) ? run_len[d] : lo_min[d];
              lo_max[d] = (run_len[d] > lo_max[d]) ? run_len[d] : lo_max[d];
            end
          end
          run_len[d] = 0;
        end
        run_len[d]++;
        if (m_rdy[d]) begin
          if (have_strobe[d] && (cyc - last_t[d]) < gap_min[d]) gap_min[d] = cyc - last_t[d];
          last_t[d] = cyc;
          have_strobe[d] = 1;
        end
      end else if (!prev_cs[d]) begin
        len_last[d] = cs_len[d];
      end
      prev_cs[d]   = m_cs[d];
      prev_sclk[d] = m_sclk[d];
    end
  end

  task automatic wait_busy4(input logic want, input int budget, input string tag);
    int n = 0;
    while (bus4.busy !== want && n < budget) begin @(negedge clk); n++; end
    check(tag, 32'(bus4.busy), 32'(want));
  endtask

  task automatic frame4(input int pulse_delay, input int n_pulses, input bit drop_en);
    q4.delete();
    bus4.drdy_n = 1'b0;
    repeat (4) @(negedge clk);
    bus4.drdy_n = 1'b1;
    wait_busy4(1'b1, 20, "frame_start");
    if (n_pulses > 0) begin
      repeat (pulse_delay) @(negedge clk);
      for (int i = 0; i < n_pulses; i++) begin
        bus4.drdy_n = 1'b0; repeat (4) @(negedge clk);
        bus4.drdy_n = 1'b1; repeat (4) @(negedge clk);
      end
    end
    if (drop_en) begin
      repeat (100) @(negedge clk);
      bus4.enable = 1'b0;
    end
    wait_busy4(1'b0, 2000, "frame_end");
    repeat (3) @(negedge clk);
    bus4.enable = 1'b1;
  endtask

  task automatic rand_frame4(input logic [3:0] hdr);
    fw4[0] = {hdr, 20'($urandom)};
    for (int i = 1; i < FRAME_WORDS; i++) fw4[i] = 24'($urandom);
  endtask

  // A valid header yields all channel words in order; otherwise nothing and the sample holds.
  task automatic expect_frame4(input string tag);
    bit good;
    good       = (fw4[0][23:20] == 4'hC);
    exp_status = fw4[0];
    exp_err    = !good;
    check({tag, "/n_strobes"}, 32'(q4.size()), good ? 32'd8 : 32'd0);
    if (good) begin
      for (int i = 0; i < 8 && i < q4.size(); i++) begin
        check($sformatf("%s/sel%0d", tag, i), 32'(q4[i][26:24]), 32'(i));
        check($sformatf("%s/data%0d", tag, i), 32'(q4[i][23:0]), 32'(fw4[i + 1]));
      end
      exp_raw = fw4[8];
      exp_sel = 3'd7;
      check({tag, "/gap_ok"}, 32'(gap_min[0] >= 2 * 4 * 24), 32'd1);
    end
    check({tag, "/status"},  32'(bus4.status_word), 32'(exp_status));
    check({tag, "/err"},     32'(bus4.frame_err), 32'(exp_err));
    check({tag, "/raw"},     32'(bus4.raw_adc_out), 32'(exp_raw));
    check({tag, "/sel"},     32'(bus4.adc_channel_sel), 32'(exp_sel));
    check({tag, "/overrun"}, 32'(bus4.overrun_cnt), 32'(exp_ovr));
    check({tag, "/cs_len"},  32'(len_last[0]), 32'(4 * (2 * FRAME_BITS + 2)));
    check({tag, "/rises"},   32'(rises[0]), 32'(FRAME_BITS));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "/cs_n"},    32'(bus4.spi_cs_n), 32'd1);
    check({tag, "/sclk"},    32'(bus4.spi_sclk), 32'd0);
    check({tag, "/busy"},    32'(bus4.busy), 32'd0);
    check({tag, "/raw"},     32'(bus4.raw_adc_out), 32'd0);
    check({tag, "/sel"},     32'(bus4.adc_channel_sel), 32'd0);
    check({tag, "/ready"},   32'(bus4.adc_data_ready), 32'd0);
    check({tag, "/status"},  32'(bus4.status_word), 32'd0);
    check({tag, "/err"},     32'(bus4.frame_err), 32'd0);
    check({tag, "/overrun"}, 32'(bus4.overrun_cnt), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit any_active;
    int n;
    rst = 1'b1;
    bus4.enable = 1'b1; bus4.drdy_n = 1'b1;
    bus2.enable = 1'b1; bus2.drdy_n = 1'b1;
    exp_raw = '0; exp_sel = '0; exp_status = '0; exp_err = 1'b0; exp_ovr = 0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Directed frame from the datasheet-style pattern
    fw4 = '{24'hC00000, 24'h000001, 24'h7FFFFF, 24'h800000, 24'h123456,
            24'hABCDEF, 24'h000000, 24'hFFFFFF, 24'h55AA55};
    frame4(0, 0, 1'b0);
    expect_frame4("directed");
    check("directed/sclk_hi_min", 32'(hi_min[0]), 32'd4);
    check("directed/sclk_hi_max", 32'(hi_max[0]), 32'd4);
    check("directed/sclk_lo_min", 32'(lo_min[0]), 32'd4);
    check("directed/sclk_lo_max", 32'(lo_max[0]), 32'd4);

    for (int r = 0; r < 3; r++) begin
      rand_frame4(4'hC);
      frame4(0, 0, 1'b0);
      expect_frame4($sformatf("rand%0d", r));
    end

    // Bad headers: fixed 0x4 and a random non-0xC nibble, then recovery
    rand_frame4(4'h4);
    fw4[0] = 24'h400000;
    frame4(0, 0, 1'b0);
    expect_frame4("bad_hdr");
    begin
      logic [3:0] nib;
      nib = 4'($urandom_range(0, 14));
      if (nib >= 4'hC) nib = nib + 4'd1;
      rand_frame4(nib);
    end
    frame4(0, 0, 1'b0);
    expect_frame4("bad_rand");
    rand_frame4(4'hC);
    frame4(0, 0, 1'b0);
    expect_frame4("recover");

    // Overrun: one extra edge ~500 clk in, then enough to saturate
    rand_frame4(4'hC);
    frame4(490, 1, 1'b0);
    exp_ovr = exp_ovr + 1;
    expect_frame4("overrun1");
    for (int r = 0; r < 2; r++) begin
      rand_frame4(4'hC);
      frame4(20, 150, 1'b0);
      exp_ovr = (exp_ovr + 150 > 255) ? 255 : exp_ovr + 150;
      expect_frame4($sformatf("overrun_sat%0d", r));
    end

    // DRDY edge while disabled is ignored
    bus4.enable = 1'b0;
    q4.delete();
    bus4.drdy_n = 1'b0; repeat (4) @(negedge clk); bus4.drdy_n = 1'b1;
    any_active = 1'b0;
    repeat (40) begin
      @(negedge clk);
      any_active |= !bus4.spi_cs_n | bus4.busy;
    end
    check("disabled/active", 32'(any_active), 32'd0);
    check("disabled/n_strobes", 32'(q4.size()), 32'd0);
    check("disabled/overrun", 32'(bus4.overrun_cnt), 32'(exp_ovr));
    bus4.enable = 1'b1;

    rand_frame4(4'hC);
    frame4(0, 0, 1'b1);
    expect_frame4("enable_drop");

    // Reset around bit 100 of a frame
    rand_frame4(4'hC);
    q4.delete();
    bus4.drdy_n = 1'b0; repeat (4) @(negedge clk); bus4.drdy_n = 1'b1;
    n = 0;
    while (falls[0] < 100 && n < 2000) begin @(negedge clk); n++; end
    check("mid_rst/reached_bit100", 32'(falls[0] >= 100), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    rst = 1'b0;
    exp_raw = '0; exp_sel = '0; exp_status = '0; exp_err = 1'b0; exp_ovr = 0;
    repeat (3) @(negedge clk);
    rand_frame4(4'hC);
    frame4(0, 0, 1'b0);
    expect_frame4("post_rst");

    // CLK_DIV = 2 instance: SCLK shape and stream
    fw2[0] = {4'hC, 20'($urandom)};
    for (int i = 1; i < FRAME_WORDS; i++) fw2[i] = 24'($urandom);
    q2.delete();
    bus2.drdy_n = 1'b0; repeat (4) @(negedge clk); bus2.drdy_n = 1'b1;
    n = 0;
    while (bus2.busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("div2/start", 32'(bus2.busy), 32'd1);
    n = 0;
    while (bus2.busy !== 1'b0 && n < 1200) begin @(negedge clk); n++; end
    check("div2/end", 32'(bus2.busy), 32'd0);
    repeat (3) @(negedge clk);
    check("div2/cs_len", 32'(len_last[1]), 32'(2 * (2 * FRAME_BITS + 2)));
    check("div2/rises", 32'(rises[1]), 32'(FRAME_BITS));
    check("div2/sclk_hi_min", 32'(hi_min[1]), 32'd2);
    check("div2/sclk_hi_max", 32'(hi_max[1]), 32'd2);
    check("div2/sclk_lo_min", 32'(lo_min[1]), 32'd2);
    check("div2/sclk_lo_max", 32'(lo_max[1]), 32'd2);
    check("div2/n_strobes", 32'(q2.size()), 32'd8);
    for (int i = 0; i < 8 && i < q2.size(); i++)
      check($sformatf("div2/data%0d", i), 32'(q2[i]), 32'({3'(i), fw2[i + 1]}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
